// File: rtl/varint_zigzag_ser.sv
// Protobuf varint serializer: optional zigzag / 32-bit masking of a raw field
// value, then LEB128-style 7-bit grouping, registered with one cycle latency.
module varint_zigzag_ser (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [63:0] value,
  input  logic [4:0]  field_type,
  output logic [79:0] enc,
  output logic [3:0]  len,
  output logic [63:0] operand,
  output logic        valid
);

  localparam logic [4:0] FT_INT32    = 5'd0;
  localparam logic [4:0] FT_UINT32   = 5'd2;
  localparam logic [4:0] FT_INT32_B  = 5'd5;
  localparam logic [4:0] FT_FIXED32  = 5'd7;
  localparam logic [4:0] FT_UINT32_B = 5'd13;
  localparam logic [4:0] FT_ENUM32   = 5'd15;
  localparam logic [4:0] FT_SINT32   = 5'd17;
  localparam logic [4:0] FT_SINT64   = 5'd18;

  logic        zz_en;
  logic        is_32;
  logic [63:0] operand_d, operand_q;
  logic [79:0] enc_d, enc_q;
  logic [3:0]  len_d, len_q;
  logic        valid_d, valid_q;
  logic [6:0]  grp [10];

  function automatic logic [63:0] shape_operand(input logic [63:0] v,
                                                input logic zz, input logic n32);
    logic [31:0] lo;
    logic [63:0] r;
    lo = v[31:0];
    if (zz && n32)      r = {32'd0, {lo[30:0], 1'b0} ^ {32{lo[31]}}};
    else if (zz)        r = {v[62:0], 1'b0} ^ {64{v[63]}};
    else if (n32)       r = v & 64'h0000_0000_FFFF_FFFF;
    else                r = v;
    return r;
  endfunction

  always_comb begin
    zz_en = (field_type == FT_SINT32) || (field_type == FT_SINT64);
    is_32 = (field_type == FT_INT32)   || (field_type == FT_UINT32)   ||
            (field_type == FT_INT32_B) || (field_type == FT_FIXED32)  ||
            (field_type == FT_UINT32_B)|| (field_type == FT_ENUM32)   ||
            (field_type == FT_SINT32);
    operand_d = shape_operand(value, zz_en, is_32);
  end

  // Group 9 carries only the top operand bit.
  always_comb begin
    for (int k = 0; k < 9; k++) grp[k] = operand_d[7*k +: 7];
    grp[9] = {6'd0, operand_d[63]};
  end

  always_comb begin
    len_d = 4'd1;
    for (int k = 0; k < 10; k++)
      if (grp[k] != 7'd0) len_d = 4'(k + 1);
    enc_d = '0;
    for (int k = 0; k < 10; k++)
      if (k < int'(len_d))
        enc_d[8*k +: 8] = {(k < int'(len_d) - 1), grp[k]};
  end

  always_comb begin
    valid_d = en;
  end

  // Output stage: results load only on a capture, otherwise hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      operand_q <= '0;
      enc_q     <= '0;
      len_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (en) begin
        operand_q <= operand_d;
        enc_q     <= enc_d;
        len_q     <= len_d;
      end
    end
  end

  assign enc     = enc_q;
  assign len     = len_q;
  assign operand = operand_q;
  assign valid   = valid_q;

endmodule

// File: tb/tb_varint_zigzag_ser.sv
// Directed bench for varint_zigzag_ser with hand-computed expected encodings.
module tb_varint_zigzag_ser;

  logic        clk;
  logic        reset;
  logic        en;
  logic [63:0] value;
  logic [4:0]  field_type;
  logic [79:0] enc;
  logic [3:0]  len;
  logic [63:0] operand;
  logic        valid;

  int passed = 0;
  int total  = 0;

  varint_zigzag_ser dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .value      (value),
    .field_type (field_type),
    .enc        (enc),
    .len        (len),
    .operand    (operand),
    .valid      (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic capture(input logic [4:0] ft, input logic [63:0] v);
    @(negedge clk);
    en = 1'b1;
    field_type = ft;
    value = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_res(input string tag, input logic [63:0] op,
                            input logic [79:0] e, input logic [3:0] l);
    check({tag, "_valid"}, 80'(valid), 80'd1);
    check({tag, "_operand"}, 80'(operand), 80'(op));
    check({tag, "_enc"}, enc, e);
    check({tag, "_len"}, 80'(len), 80'(l));
  endtask

  initial begin
    reset = 1'b0;
    en = 1'b0;
    value = '0;
    field_type = '0;
    #2;
    check("rst_enc", enc, 80'd0);
    check("rst_len", 80'(len), 80'd0);
    check("rst_operand", 80'(operand), 80'd0);
    check("rst_valid", 80'(valid), 80'd0);
    @(negedge clk);
    reset = 1'b1;

    capture(5'd4, 64'd300);
    expect_res("u64_300", 64'h12C, 80'h02AC, 4'd2);

    // Back-to-back captures, one result per cycle.
    capture(5'd17, 64'hFFFF_FFFF_FFFF_FFFF);
    expect_res("s32_m1", 64'd1, 80'h01, 4'd1);
    capture(5'd17, 64'd1);
    expect_res("s32_p1", 64'd2, 80'h02, 4'd1);
    capture(5'd18, 64'hFFFF_FFFF_FFFF_FFFE);
    expect_res("s64_m2", 64'd3, 80'h03, 4'd1);
    capture(5'd18, 64'h8000_0000_0000_0000);
    expect_res("s64_min", 64'hFFFF_FFFF_FFFF_FFFF, 80'h01_FF_FF_FF_FF_FF_FF_FF_FF_FF, 4'd10);
    capture(5'd4, 64'hFFFF_FFFF_FFFF_FFFF);
    expect_res("u64_max", 64'hFFFF_FFFF_FFFF_FFFF, 80'h01_FF_FF_FF_FF_FF_FF_FF_FF_FF, 4'd10);
    capture(5'd5, 64'hFFFF_FFFF_FFFF_FFFF);
    expect_res("i32_m1", 64'hFFFF_FFFF, 80'h0F_FF_FF_FF_FF, 4'd5);
    capture(5'd0, 64'hFFFF_FFFF_8000_0000);
    expect_res("ft0_mask", 64'h8000_0000, 80'h08_80_80_80_80, 4'd5);
    capture(5'd31, 64'h0000_0001_0000_0000);
    expect_res("ft31_64b", 64'h1_0000_0000, 80'h10_80_80_80_80, 4'd5);
    capture(5'd4, 64'd128);
    expect_res("u64_128", 64'd128, 80'h0180, 4'd2);
    capture(5'd18, 64'd0);
    expect_res("zero_s64", 64'd0, 80'd0, 4'd1);
    capture(5'd4, 64'd300);
    expect_res("u64_300b", 64'h12C, 80'h02AC, 4'd2);

    // en low: valid drops, results hold.
    idle();
    check("hold_valid", 80'(valid), 80'd0);
    check("hold_enc", enc, 80'h02AC);
    check("hold_len", 80'(len), 80'd2);
    check("hold_operand", 80'(operand), 80'h12C);

    // Reset with a capture pending: immediate clear, no valid pulse.
    @(negedge clk);
    en = 1'b1;
    field_type = 5'd4;
    value = 64'd5;
    #1;
    reset = 1'b0;
    #1;
    check("arst_enc", enc, 80'd0);
    check("arst_len", 80'(len), 80'd0);
    check("arst_operand", 80'(operand), 80'd0);
    check("arst_valid", 80'(valid), 80'd0);
    @(posedge clk);
    #1;
    check("arst_edge_valid", 80'(valid), 80'd0);
    check("arst_edge_enc", enc, 80'd0);
    @(negedge clk);
    en = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_valid", 80'(valid), 80'd0);
    check("post_rst_len", 80'(len), 80'd0);

    capture(5'd4, 64'd5);
    expect_res("first_after_rst", 64'd5, 80'h05, 4'd1);
    idle();
    check("final_valid", 80'(valid), 80'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
